sr_ls: RTL and testbench
========================

// Module: sr_ls
// PURPOSE
//  Serial-in, serial-out left-shift register of WIDTH bits. Each clock, si enters the LSB and contents move one place toward the MSB.
//  so is the MSB, so a bit on si appears on so WIDTH clocks later.
//  Used as a fixed serial delay line and bit-serialiser stage in the datapath.
// PARAMETERS
//  WIDTH  4  number of register stages; legal range 2..64, compile-time error outside this range
// PORTS
//  clk   in   1      single clock; all state updates on the rising edge
//  rst   in   1      synchronous, active-high reset
//  si    in   1      serial data in, sampled on each rising edge
//  so    out  1      serial data out = sr[WIDTH-1]
// BEHAVIOUR
//  - One clock (clk); reset rst is synchronous and active-high.
//  - Internal state: reg sr[WIDTH-1:0]. It must keep the hierarchical name `sr` so benches can probe uut.sr.
//  - Reset: on a rising edge with rst=1, sr <= 0. so therefore reads 0 from the following edge.
//  - Otherwise, each rising edge: sr <= {sr[WIDTH-2:0], si}. The old sr[WIDTH-1] is discarded.
//  - There is no enable: the register shifts on every edge while not in reset.
//  - so is driven combinationally from sr[WIDTH-1]; no extra output register.
//  - Latency: si sampled at edge N appears on so after edge N+WIDTH-1, i.e. on the WIDTH-th edge counting edge N as the first.
//  - Reset mid-stream: clears all in-flight bits; reset takes priority over shifting on the same edge.
//  - After release (rst 1->0), the first shift occurs on the next edge with rst=0.
//  - si = X/Z is not sanitised; it propagates as X. The bench must drive si with known values.
//  - Power-up before the first reset: sr undefined in simulation. The FPGA init value is 0.
// CONFIGURATION
//  Macro SR_LS_PAR_OUT_EN:
//  - Defined: adds output port `po  out  WIDTH  parallel view of sr`, po = sr combinationally.
//    po reads all-zeros on the cycle after reset.
//  - Undefined: port po is absent and behaviour is otherwise identical.
// STRUCTURE
//  - Package sr_ls_pkg:
//    - localparam SR_LS_DEFAULT_WIDTH = 4.
//    - function sr_ls_shift(sr, si) returning {sr[W-2:0], si}, shared with the bench reference model.
//  - One sub-module, sr_ls_stage: a 1-bit D flop with synchronous active-high reset.
//    sr_ls instantiates WIDTH of these in a generate loop, chained LSB->MSB.
//  - Simulation-only assertions under `ifndef SYNTHESIS`:
//    - sr==0 the cycle after rst.
//    - so == sr[WIDTH-1] at all times.
//    - Parameter range check on WIDTH.
// TESTING (WIDTH=4 unless noted)
//  1. Reset: rst=1 for 1 edge, si=1 -> sr=0000, so=0.
//  2. Pattern: rst=0, si=1,0,1,1,0 on successive edges -> sr=0001,0010,0101,1011,0110; so=0,0,0,1,0.
//  3. Latency: single 1 pulse on si then zeros -> so=1 exactly on the 4th edge, 0 on all other edges.
//  4. Mid-stream reset: load 1111, assert rst with si=1 -> sr=0000 next edge.
//     Then deassert rst, si=1 -> sr=0001.
//  5. Flush: after loading 1011, drive si=0 for 4 edges -> so=1,0,1,1 then sr=0000.
//  6. With SR_LS_PAR_OUT_EN and WIDTH=8: shift in 0xA5 MSB-first -> po=8'hA5 and so=1.
//     Repeat without the macro, confirm build has no po port and so matches the same sequence.
//  Bench compares against sr_ls_shift every cycle and runs for both WIDTH=4 and WIDTH=8.

Source files
------------

// File: rtl/sr_ls_pkg.sv
// Shared definitions for the sr_ls serial shift register.
// Provides the width limits, the default width and the one-step shift function.
// The shift function is also used by the testbench reference model.
package sr_ls_pkg;

    localparam int unsigned SR_LS_DEFAULT_WIDTH = 4;
    localparam int unsigned SR_LS_MIN_WIDTH     = 2;
    localparam int unsigned SR_LS_MAX_WIDTH     = 64;

    // One left shift of a w-bit register held in a max-width vector.
    // si enters the LSB, and bits at position w and above are cleared.
    function automatic logic [SR_LS_MAX_WIDTH-1:0] sr_ls_shift(
        input logic [SR_LS_MAX_WIDTH-1:0] sr,
        input logic                       si,
        input int unsigned                w
    );
        logic [SR_LS_MAX_WIDTH-1:0] mask;
        if (w >= SR_LS_MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (SR_LS_MAX_WIDTH'(1) << w) - SR_LS_MAX_WIDTH'(1);
        end
        return {sr[SR_LS_MAX_WIDTH-2:0], si} & mask;
    endfunction

endpackage

// File: rtl/sr_ls_stage.sv
// One stage of the sr_ls chain: a 1-bit D flop with synchronous active-high reset.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, forces q to 0
//   d    in   next bit
//   q    out  stored bit
module sr_ls_stage (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sr_ls.sv
// Serial-in, serial-out left-shift register of WIDTH stages.
// Each edge si enters the LSB and everything moves one place toward the MSB.
// so is the MSB, so a bit on si appears on so on the WIDTH-th edge.
// Optional feature macro: SR_LS_PAR_OUT_EN adds the parallel output po.
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      synchronous active-high reset, clears every stage
//   si   in   1      serial data in
//   so   out  1      serial data out, sr[WIDTH-1], combinational
//   po   out  WIDTH  parallel view of sr (only with SR_LS_PAR_OUT_EN)
module sr_ls
    import sr_ls_pkg::*;
#(
    parameter int unsigned WIDTH = SR_LS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
`ifdef SR_LS_PAR_OUT_EN
    output logic [WIDTH-1:0] po,
`endif
    output logic             so
);

    // Reject unsupported widths at elaboration.
    if ((WIDTH < SR_LS_MIN_WIDTH) || (WIDTH > SR_LS_MAX_WIDTH)) begin : g_bad_width
        $error("sr_ls: WIDTH must lie in 2..64");
    end

    // Register contents; the name sr is probed hierarchically.
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;

    // Next value of the whole chain: contents shifted up by one with si in the LSB.
    assign sr_next = WIDTH'(sr_ls_shift(SR_LS_MAX_WIDTH'(sr), si, WIDTH));

    // Flop chain, LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        sr_ls_stage u_stage (
            .clk (clk),
            .rst (rst),
            .d   (sr_next[i]),
            .q   (sr[i])
        );
    end

    assign so = sr[WIDTH-1];

`ifdef SR_LS_PAR_OUT_EN
    assign po = sr;
`endif

`ifndef SYNTHESIS
    // Reset empties the register by the following edge.
    a_reset_clears: assert property (@(posedge clk) rst |=> (sr == '0))
        else $error("sr_ls: sr not cleared after reset");

    // Serial output always tracks the MSB.
    a_so_is_msb: assert property (@(posedge clk) so == sr[WIDTH-1])
        else $error("sr_ls: so differs from sr MSB");
`endif

endmodule

// File: tb/tb_sr_ls.sv
// Directed testbench for sr_ls at WIDTH=4 and WIDTH=8 side by side.
// Both instances share rst and si; every edge their sr and so are compared
// against a reference model built on sr_ls_shift, and the directed steps add
// hand-computed expectations for reset, pattern, latency, mid-stream reset,
// flush and the 0xA5 load.
module tb_sr_ls;
    import sr_ls_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       si  = 1'b0;
    logic       so4;
    logic       so8;
`ifdef SR_LS_PAR_OUT_EN
    logic [3:0] po4;
    logic [7:0] po8;
`endif

    int checks   = 0;
    int failures = 0;

    logic [63:0] m4;
    logic [63:0] m8;

    always #5 clk = ~clk;

    sr_ls #(.WIDTH(4)) u4 (
        .clk (clk),
        .rst (rst),
        .si  (si),
`ifdef SR_LS_PAR_OUT_EN
        .po  (po4),
`endif
        .so  (so4)
    );

    sr_ls #(.WIDTH(8)) u8 (
        .clk (clk),
        .rst (rst),
        .si  (si),
`ifdef SR_LS_PAR_OUT_EN
        .po  (po8),
`endif
        .so  (so8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge with the given rst/si, then compare both instances to the model.
    task automatic step(input logic r, input logic s);
        rst = r;
        si  = s;
        @(posedge clk);
        #1;
        if (r) begin
            m4 = '0;
            m8 = '0;
        end else begin
            m4 = sr_ls_shift(m4, s, 4);
            m8 = sr_ls_shift(m8, s, 8);
        end
        check("model_sr4", 64'(u4.sr), m4);
        check("model_sr8", 64'(u8.sr), m8);
        check("model_so4", 64'(so4), 64'(m4[3]));
        check("model_so8", 64'(so8), 64'(m8[7]));
`ifdef SR_LS_PAR_OUT_EN
        check("model_po4", 64'(po4), m4);
        check("model_po8", 64'(po8), m8);
`endif
    endtask

    initial begin
        logic [4:0] pat_si;
        logic [3:0] pat_sr [5];
        logic [4:0] pat_so;
        logic [3:0] flush_so;
        logic [7:0] byte_a5;

        m4 = 'x;
        m8 = 'x;
        @(negedge clk);

        // Reset with si high.
        step(1'b1, 1'b1);
        check("reset_sr", 64'(u4.sr), 64'h0);
        check("reset_so", 64'(so4), 64'h0);

        // Pattern 1,0,1,1,0.
        pat_si    = 5'b01101;
        pat_sr[0] = 4'b0001;
        pat_sr[1] = 4'b0010;
        pat_sr[2] = 4'b0101;
        pat_sr[3] = 4'b1011;
        pat_sr[4] = 4'b0110;
        pat_so    = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, pat_si[i]);
            check("pattern_sr", 64'(u4.sr), 64'(pat_sr[i]));
            check("pattern_so", 64'(so4), 64'(pat_so[i]));
        end

        // Single pulse: so high on the 4th edge only.
        step(1'b1, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, (e == 1) ? 1'b1 : 1'b0);
            check("latency_so", 64'(so4), (e == 4) ? 64'h1 : 64'h0);
        end
        check("latency_sr8_pulse", 64'(u8.sr), 64'h20);

        // Mid-stream reset with si high.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check("load_ones_sr", 64'(u4.sr), 64'hF);
        step(1'b1, 1'b1);
        check("midreset_sr", 64'(u4.sr), 64'h0);
        check("midreset_sr8", 64'(u8.sr), 64'h0);
        step(1'b0, 1'b1);
        check("release_sr", 64'(u4.sr), 64'h1);

        // Flush 1011 with zeros; so seen before each flush edge.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("flush_load_sr", 64'(u4.sr), 64'hB);
        flush_so = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            check("flush_so", 64'(so4), 64'(flush_so[i]));
            step(1'b0, 1'b0);
        end
        check("flush_sr", 64'(u4.sr), 64'h0);
        check("flush_so_end", 64'(so4), 64'h0);

        // Shift 0xA5 MSB-first.
        step(1'b1, 1'b0);
        byte_a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) step(1'b0, byte_a5[i]);
        check("a5_sr8", 64'(u8.sr), 64'hA5);
        check("a5_so8", 64'(so8), 64'h1);
        check("a5_sr4", 64'(u4.sr), 64'h5);
        check("a5_so4", 64'(so4), 64'h0);
`ifdef SR_LS_PAR_OUT_EN
        check("a5_po8", 64'(po8), 64'hA5);
`endif

        // Reset at the boundary of a full register.
        step(1'b1, 1'b1);
        check("final_reset_sr8", 64'(u8.sr), 64'h0);
        check("final_reset_so8", 64'(so8), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
